// File: rtl/picobello_sam_lookup.sv
// Runtime-programmable system-address-map lookup for the picobello mesh.
// Translates an address to (x, y, rule) with one registered result stage and valid/ready on both sides.
module picobello_sam_lookup #(
  parameter int unsigned AddrWidth    = 48,
  parameter int unsigned NumRules     = 16,
  parameter int unsigned MeshDimX     = 4,
  parameter int unsigned MeshDimY     = 4,
  parameter int unsigned XWidth       = 3,
  parameter int unsigned YWidth       = 3,
  parameter int unsigned RuleIdxWidth = (NumRules > 1) ? $clog2(NumRules) : 1,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_we_i,
  input  logic [RuleIdxWidth-1:0]       cfg_idx_i,
  input  logic [AddrWidth-1:0]          cfg_start_i,
  input  logic [AddrWidth-1:0]          cfg_end_i,
  input  logic [XWidth-1:0]             cfg_x_i,
  input  logic [YWidth-1:0]             cfg_y_i,
  input  logic                          cfg_en_i,
  input  logic                          cfg_map_we_i,
  input  logic [MeshDimX*MeshDimY-1:0]  cfg_map_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_addr_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [XWidth-1:0]             rsp_x_o,
  output logic [YWidth-1:0]             rsp_y_o,
  output logic [RuleIdxWidth-1:0]       rsp_rule_o,
  output logic [1:0]                    rsp_err_o,
  output logic [CntWidth-1:0]           err_cnt_o
);

  localparam int unsigned MapWidth    = MeshDimX * MeshDimY;
  localparam int unsigned MapIdxWidth = (MapWidth > 1) ? $clog2(MapWidth) : 1;
  localparam logic [XWidth:0] MeshX   = (XWidth+1)'(MeshDimX);
  localparam logic [YWidth:0] MeshY   = (YWidth+1)'(MeshDimY);

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrMiss  = 2'd1;
  localparam logic [1:0] ErrMesh  = 2'd2;
  localparam logic [1:0] ErrDummy = 2'd3;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] value);
    return (&value) ? value : value + CntWidth'(1);
  endfunction

  logic [AddrWidth-1:0] rule_start [NumRules];
  logic [AddrWidth-1:0] rule_end   [NumRules];
  logic [XWidth-1:0]    rule_x     [NumRules];
  logic [YWidth-1:0]    rule_y     [NumRules];
  logic                 rule_en    [NumRules];
  logic [MapWidth-1:0]  tile_map;

  // Out-of-range indices match no entry and are silently dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumRules); i++) begin
        rule_start[i] <= '0;
        rule_end[i]   <= '0;
        rule_x[i]     <= '0;
        rule_y[i]     <= '0;
        rule_en[i]    <= 1'b0;
      end
      tile_map <= '1;
    end else begin
      if (cfg_we_i) begin
        for (int i = 0; i < int'(NumRules); i++) begin
          if (cfg_idx_i == RuleIdxWidth'(i)) begin
            rule_start[i] <= cfg_start_i;
            rule_end[i]   <= cfg_end_i;
            rule_x[i]     <= cfg_x_i;
            rule_y[i]     <= cfg_y_i;
            rule_en[i]    <= cfg_en_i;
          end
        end
      end
      if (cfg_map_we_i) tile_map <= cfg_map_i;
    end
  end

  // Stage p0: combinational decode against the current table
  logic                    hit_p0;
  logic [RuleIdxWidth-1:0] hit_idx_p0;
  logic [XWidth-1:0]       hit_x_p0;
  logic [YWidth-1:0]       hit_y_p0;
  logic [MapIdxWidth-1:0]  map_idx_p0;
  logic [1:0]              err_p0;
  logic [XWidth-1:0]       x_p0;
  logic [YWidth-1:0]       y_p0;
  logic                    req_hs;

  always_comb begin
    hit_p0     = 1'b0;
    hit_idx_p0 = '0;
    hit_x_p0   = '0;
    hit_y_p0   = '0;
    // Descending scan so the lowest matching index is the last to assign.
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (rule_en[i] && (req_addr_i >= rule_start[i]) && (req_addr_i < rule_end[i])) begin
        hit_p0     = 1'b1;
        hit_idx_p0 = RuleIdxWidth'(i);
        hit_x_p0   = rule_x[i];
        hit_y_p0   = rule_y[i];
      end
    end
    map_idx_p0 = MapIdxWidth'(int'(hit_x_p0) * int'(MeshDimY) + int'(hit_y_p0));
    if (!hit_p0)                                                        err_p0 = ErrMiss;
    else if (({1'b0, hit_x_p0} >= MeshX) || ({1'b0, hit_y_p0} >= MeshY)) err_p0 = ErrMesh;
    else if (!tile_map[map_idx_p0])                                     err_p0 = ErrDummy;
    else                                                                err_p0 = ErrNone;
    x_p0 = (err_p0 == ErrNone) ? hit_x_p0 : '0;
    y_p0 = (err_p0 == ErrNone) ? hit_y_p0 : '0;
  end

  // Stage p1: result register, loaded only on the request handshake
  logic                    vld_p1;
  logic [XWidth-1:0]       x_p1;
  logic [YWidth-1:0]       y_p1;
  logic [RuleIdxWidth-1:0] rule_p1;
  logic [1:0]              err_p1;
  logic [CntWidth-1:0]     err_cnt_p1;

  assign req_ready_o = !vld_p1 || rsp_ready_i;
  assign req_hs      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1     <= 1'b0;
      x_p1       <= '0;
      y_p1       <= '0;
      rule_p1    <= '0;
      err_p1     <= ErrNone;
      err_cnt_p1 <= '0;
    end else if (req_hs) begin
      vld_p1  <= 1'b1;
      x_p1    <= x_p0;
      y_p1    <= y_p0;
      rule_p1 <= hit_idx_p0;
      err_p1  <= err_p0;
      if (err_p0 != ErrNone) err_cnt_p1 <= sat_inc(err_cnt_p1);
    end else if (rsp_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rsp_valid_o = vld_p1;
  assign rsp_x_o     = x_p1;
  assign rsp_y_o     = y_p1;
  assign rsp_rule_o  = rule_p1;
  assign rsp_err_o   = err_p1;
  assign err_cnt_o   = err_cnt_p1;

endmodule

// File: tb/tb_picobello_sam_lookup.sv
// Scoreboard bench for picobello_sam_lookup: a rule-table model predicts each accepted lookup,
// and a monitor compares every presented response against the oldest prediction.
module tb_picobello_sam_lookup;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [3:0]  cfg_idx_i = '0;
  logic [47:0] cfg_start_i = '0;
  logic [47:0] cfg_end_i = '0;
  logic [2:0]  cfg_x_i = '0;
  logic [2:0]  cfg_y_i = '0;
  logic        cfg_en_i = 1'b0;
  logic        cfg_map_we_i = 1'b0;
  logic [15:0] cfg_map_i = '0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [47:0] req_addr_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [2:0]  rsp_x_o;
  logic [2:0]  rsp_y_o;
  logic [3:0]  rsp_rule_o;
  logic [1:0]  rsp_err_o;
  logic [15:0] err_cnt_o;

  picobello_sam_lookup dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_start_i(cfg_start_i), .cfg_end_i(cfg_end_i),
    .cfg_x_i(cfg_x_i), .cfg_y_i(cfg_y_i), .cfg_en_i(cfg_en_i),
    .cfg_map_we_i(cfg_map_we_i), .cfg_map_i(cfg_map_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_x_o(rsp_x_o), .rsp_y_o(rsp_y_o), .rsp_rule_o(rsp_rule_o), .rsp_err_o(rsp_err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]  x;
    logic [2:0]  y;
    logic [3:0]  rule;
    logic [1:0]  err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   rand_ready = 1'b0;

  logic [47:0] m_start [16];
  logic [47:0] m_end   [16];
  logic [2:0]  m_x     [16];
  logic [2:0]  m_y     [16];
  bit          m_en    [16];
  logic [15:0] m_map;
  int          m_cnt;

  function automatic void reset_model();
    for (int i = 0; i < 16; i++) begin
      m_start[i] = '0; m_end[i] = '0; m_x[i] = '0; m_y[i] = '0; m_en[i] = 1'b0;
    end
    m_map = 16'hFFFF;
    m_cnt = 0;
  endfunction

  // First enabled rule (lowest index) containing the address decides; then mesh, then presence.
  function automatic exp_t model(input logic [47:0] a);
    exp_t e;
    int h, xi, yi;
    e = '0;
    h = -1;
    for (int i = 0; i < 16; i++)
      if (h < 0 && m_en[i] && a >= m_start[i] && a < m_end[i]) h = i;
    if (h < 0) begin
      e.err = 2'd1;
    end else begin
      e.rule = 4'(h);
      xi = int'(m_x[h]);
      yi = int'(m_y[h]);
      if (xi >= 4 || yi >= 4) e.err = 2'd2;
      else if (((m_map >> (xi * 4 + yi)) & 16'h1) == 16'h0) e.err = 2'd3;
      else begin e.x = m_x[h]; e.y = m_y[h]; end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Predictor: lookup uses the table as it stands before this cycle's writes land.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (req_valid_i && req_ready_o) begin
        e = model(req_addr_i);
        if (e.err != 2'd0 && m_cnt < 65535) m_cnt++;
        e.cnt = 16'(m_cnt);
        sb.push_back(e);
      end
      if (cfg_we_i) begin
        m_start[cfg_idx_i] = cfg_start_i;
        m_end[cfg_idx_i]   = cfg_end_i;
        m_x[cfg_idx_i]     = cfg_x_i;
        m_y[cfg_idx_i]     = cfg_y_i;
        m_en[cfg_idx_i]    = cfg_en_i;
      end
      if (cfg_map_we_i) m_map = cfg_map_i;
    end
  end

  // Monitor: whatever is presented must equal the oldest prediction, held or consumed.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      checks++;
      if (req_ready_o !== (!rsp_valid_o || rsp_ready_i)) begin
        failures++;
        $display("FAIL req_ready actual=%0b required=%0b", req_ready_o, !rsp_valid_o || rsp_ready_i);
      end
      if (rsp_valid_o) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected actual=valid required=no response");
        end else begin
          e = sb[0];
          if ({rsp_x_o, rsp_y_o, rsp_rule_o, rsp_err_o, err_cnt_o} !== e) begin
            failures++;
            $display("FAIL rsp actual x=%0d y=%0d rule=%0d err=%0d cnt=%0d required x=%0d y=%0d rule=%0d err=%0d cnt=%0d",
                     rsp_x_o, rsp_y_o, rsp_rule_o, rsp_err_o, err_cnt_o, e.x, e.y, e.rule, e.err, e.cnt);
          end
          if (rsp_ready_i) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
    if (rand_ready) rsp_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic lookup(input logic [47:0] a);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    for (int n = 0; n < 200; n++) begin
      if (req_ready_o) begin
        cyc();
        req_valid_i = 1'b0;
        return;
      end
      cyc();
    end
    req_valid_i = 1'b0;
    checks++;
    failures++;
    $display("FAIL lookup_timeout actual=no handshake required=handshake within 200 cycles");
  endtask

  task automatic set_rule(input int idx, input logic [47:0] s, input logic [47:0] e,
                          input logic [2:0] x, input logic [2:0] y, input bit en);
    cfg_idx_i = 4'(idx); cfg_start_i = s; cfg_end_i = e; cfg_x_i = x; cfg_y_i = y; cfg_en_i = en;
  endtask

  task automatic wr_rule(input int idx, input logic [47:0] s, input logic [47:0] e,
                         input logic [2:0] x, input logic [2:0] y, input bit en);
    set_rule(idx, s, e, x, y, en);
    cfg_we_i = 1'b1;
    cyc();
    cfg_we_i = 1'b0;
  endtask

  task automatic wr_map(input logic [15:0] m);
    cfg_map_i = m;
    cfg_map_we_i = 1'b1;
    cyc();
    cfg_map_we_i = 1'b0;
  endtask

  task automatic drain();
    rsp_ready_i = 1'b1;
    for (int n = 0; n < 50 && sb.size() > 0; n++) cyc();
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0 pending", sb.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_model();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    chk("reset_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_x", 64'(rsp_x_o), 64'd0);
    chk("reset_y", 64'(rsp_y_o), 64'd0);
    chk("reset_rule", 64'(rsp_rule_o), 64'd0);
    chk("reset_err", 64'(rsp_err_o), 64'd0);
    chk("reset_cnt", 64'(err_cnt_o), 64'd0);
    chk("reset_ready", 64'(req_ready_o), 64'd1);

    // Directed scenarios
    lookup(48'h1000);
    chk("first_valid", 64'(rsp_valid_o), 64'd1);
    chk("first_err", 64'(rsp_err_o), 64'd1);
    chk("first_cnt", 64'(err_cnt_o), 64'd1);
    wr_rule(2, 48'h1000_0000, 48'h1004_0000, 3'd1, 3'd2, 1'b1);
    lookup(48'h1003_FFFF);
    lookup(48'h1004_0000);
    wr_rule(0, 48'h1000_0000, 48'h1001_0000, 3'd0, 3'd0, 1'b1);
    lookup(48'h1000_8000);
    wr_rule(1, 48'h2000_0000, 48'h2001_0000, 3'd4, 3'd0, 1'b1);
    lookup(48'h2000_0010);
    wr_map(16'hFFBF);
    lookup(48'h1002_0000);
    wr_map(16'hFFFF);
    lookup(48'h1002_0000);
    drain();

    // Backpressure then bubble-free back-to-back
    rsp_ready_i = 1'b0;
    chk("bp_ready_empty", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_addr_i  = 48'h1002_0000;
    cyc();
    req_addr_i  = 48'h1000_0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", 64'(req_ready_o), 64'd0);
      cyc();
    end
    rsp_ready_i = 1'b1;
    cyc();
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", 64'(req_ready_o), 64'd1);
      lookup(48'h1003_0000 + 48'(i));
      chk("b2b_valid", 64'(rsp_valid_o), 64'd1);
    end
    drain();

    // Write and lookup in the same cycle sees the old table
    set_rule(3, 48'h3000_0000, 48'h3000_1000, 3'd2, 3'd3, 1'b1);
    cfg_we_i    = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i  = 48'h3000_0800;
    cyc();
    cfg_we_i    = 1'b0;
    req_valid_i = 1'b0;
    chk("samecyc_err", 64'(rsp_err_o), 64'd1);
    lookup(48'h3000_0800);
    chk("after_write_rule", 64'(rsp_rule_o), 64'd3);
    chk("after_write_err", 64'(rsp_err_o), 64'd0);
    drain();

    // Randomized traffic
    rand_ready = 1'b1;
    for (int it = 0; it < 400; it++) begin
      int kind;
      logic [47:0] s;
      kind = $urandom_range(0, 9);
      s = 48'($urandom_range(0, 'h1FFFF));
      if (kind == 0) begin
        set_rule($urandom_range(0, 15), s,
                 ($urandom_range(0, 3) == 0) ? 48'($urandom_range(0, 'h20000)) : s + 48'($urandom_range(0, 'h8000)),
                 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)), 1'($urandom_range(0, 3) != 0));
        cfg_we_i = 1'b1;
        if ($urandom_range(0, 1) == 1) lookup(48'($urandom_range(0, 'h28000)));
        else cyc();
        cfg_we_i = 1'b0;
      end else if (kind == 1) begin
        wr_map(16'($urandom | $urandom));
      end else begin
        lookup(48'($urandom_range(0, 'h28000)));
      end
    end
    rand_ready = 1'b0;
    drain();

    // Saturate the error counter
    req_valid_i = 1'b1;
    req_addr_i  = 48'hFFFF_0000_0000;
    for (int i = 0; i < 65539; i++) cyc();
    req_valid_i = 1'b0;
    drain();
    chk("err_cnt_sat", 64'(err_cnt_o), 64'hFFFF);

    // Reset while a result is held
    wr_rule(5, 48'h5000, 48'h6000, 3'd0, 3'd1, 1'b1);
    rsp_ready_i = 1'b0;
    lookup(48'h5100);
    chk("pre_rst_valid", 64'(rsp_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_err", 64'(rsp_err_o), 64'd0);
    chk("rst_cnt", 64'(err_cnt_o), 64'd0);
    sb.delete();
    reset_model();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    lookup(48'h5100);
    chk("post_rst_miss", 64'(rsp_err_o), 64'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
